mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter sharing the core's single memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). Sits between both units and the memory interface. Accepts one request at a time, forwards it downstream with a valid/ready handshake, and routes the response back to the owner. Fairness is round-robin, and a response timeout keeps a dead bus from hanging the core.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum cycles from request acceptance to response before an error is forced (≥2)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ifu_req_valid / ifu_req_ready  in / out  1  IFU read request handshake
- ifu_addr  in  ADDR_W  IFU fetch address
- ifu_resp_valid  out  1  one-cycle IFU response strobe
- ifu_rdata  out  DATA_W  IFU read data
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_addr  in  ADDR_W  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  DATA_W  write data
- lsu_wmask  in  DATA_W/8  byte enables
- lsu_resp_valid  out  1  one-cycle LSU response strobe (read data or write ack)
- lsu_rdata  out  DATA_W  LSU read data
- mem_req_valid / mem_req_ready  out / in  1  downstream request handshake
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W, 1, DATA_W, DATA_W/8  registered request fields
- mem_resp_valid  in  1  downstream response/ack strobe
- mem_rdata  in  DATA_W  downstream read data
- bus_err  out  1  one-cycle pulse, coincident with the resp_valid of a timed-out transaction

## Operation
- FSM states: IDLE, REQ, WAIT.
- **IDLE:**
  - Picks a winner among the valid requesters and asserts only the winner's req_ready.
  - On the handshake it latches addr/wen/wdata/wmask into request registers, sets owner, clears the timeout counter, and goes to REQ.
  - IFU requests latch wen=0, wmask=0, wdata=0.
- **REQ:** mem_req_valid=1, driven from the registers, which stay stable. When mem_req_ready=1, go to WAIT.
- **WAIT:** when mem_resp_valid=1, drive the owner's resp_valid=1 and rdata=mem_rdata combinationally. Go to IDLE.
- **Arbitration:**
  - A single valid requester wins.
  - When both are valid, the requester that was not the last owner wins.
  - last_owner updates on every acceptance and resets to LSU, so the IFU wins the first contention after reset.
- **Non-owner outputs:** the non-owner's resp_valid is always 0. Both rdata outputs equal mem_rdata when not forced to 0.
- **Timeout:**
  - The counter increments in every REQ/WAIT cycle without completion.
  - On the cycle the count equals TIMEOUT−1 with no completion, the block:
    - pulses the owner's resp_valid with rdata=0,
    - pulses bus_err=1,
    - drops mem_req_valid,
    - returns to IDLE.
  - The counter saturates and does not wrap.
- **Ignored inputs:** mem_resp_valid in IDLE or REQ is ignored; late or stray responses are dropped.
- **Simultaneous events:** mem_resp_valid and timeout in the same cycle resolves as normal completion with bus_err=0.
- **Reset mid-operation:** state→IDLE, owner cleared, counter=0, last_owner=LSU. In-flight transaction abandoned with no response.
- **Reset values:**
  - All ready/valid/bus_err outputs = 0.
  - mem_addr/mem_wdata/mem_wmask/mem_wen = 0.

## Timing
- An accept in cycle N puts mem_req_valid high in N+1.
- With mem_req_ready=1 in N+1, the earliest response is N+2, visible on resp_valid in the same cycle.
- The next accept is N+3 at the earliest.
- Back-to-back throughput: one transaction per 3 cycles minimum.
- req_ready is only ever high in IDLE, for at most one requester.
- Requesters must hold valid and payload until their ready is seen.
- Timeout fires exactly TIMEOUT cycles after the accept cycle.

## Structure
- Shared package holds:
  - state enum: IDLE=2'd0, REQ=2'd1, WAIT=2'd2
  - owner constants: OWN_IFU=1'b0, OWN_LSU=1'b1
- Sub-module mem_arb_rr is the 2-way round-robin picker. Inputs: req[1:0], last_owner. Outputs: grant one-hot. Purely combinational.
- Request registers, timeout counter and FSM live in mem_arbiter.

## Test plan
- Reset then IFU-only read of 0x80000000, with mem_req_ready=1 and response 0x00100073 one cycle later → ifu_resp_valid at N+2 with ifu_rdata=0x00100073; lsu_resp_valid stays 0.
- Both valid in the same IDLE cycle after reset → IFU granted first, then LSU, then IFU; lsu_req_ready is never high together with ifu_req_ready.
- LSU write of 0xDEADBEEF to 0x80001000 with wmask 0xF, mem_req_ready held low for 5 cycles → mem_* fields stable for all 5 cycles; ack produces lsu_resp_valid=1 for one cycle.
- TIMEOUT=8 with no mem_resp_valid → exactly 8 cycles after accept, owner resp_valid=1, rdata=0, bus_err=1; mem_resp_valid injected later is ignored.
- mem_resp_valid on the timeout cycle → normal completion with data passed and bus_err=0.
- rst asserted asynchronously in WAIT → all outputs 0 immediately, no response delivered, and the next contention grants the IFU.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the IFU/LSU memory arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-way round-robin picker; bit 0 = IFU, bit 1 = LSU
import mem_arbiter_pkg::*;

module mem_arb_rr (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    // On contention the side that did not win last time goes next
    if (req == 2'b11) begin
      grant = (last_owner == OWN_LSU) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between IFU and LSU with round-robin and response timeout
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic             owner;
  logic             last_owner;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       grant;
  logic             idle;
  logic             done;
  logic             timeout;
  logic             fire;

  mem_arb_rr u_rr (
    .req        ({lsu_req_valid, ifu_req_valid}),
    .last_owner (last_owner),
    .grant      (grant)
  );

  // Ready is held low while reset is asserted even though state already reads IDLE
  assign idle          = (state == IDLE) && !rst;
  assign ifu_req_ready = idle && grant[0];
  assign lsu_req_ready = idle && grant[1];

  assign done    = (state == WAIT) && mem_resp_valid;
  assign timeout = ((state == REQ) || (state == WAIT)) && (cnt == CNT_LAST) && !done;
  assign fire    = done || timeout;

  assign ifu_resp_valid = fire && (owner == OWN_IFU);
  assign lsu_resp_valid = fire && (owner == OWN_LSU);
  assign ifu_rdata      = timeout ? '0 : mem_rdata;
  assign lsu_rdata      = timeout ? '0 : mem_rdata;
  assign bus_err        = timeout;
  assign mem_req_valid  = (state == REQ) && !timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_IFU;
      last_owner <= OWN_LSU;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ifu_req_ready || lsu_req_ready) begin
            owner      <= grant[1] ? OWN_LSU : OWN_IFU;
            last_owner <= grant[1] ? OWN_LSU : OWN_IFU;
            cnt        <= '0;
            state      <= REQ;
            if (grant[1]) begin
              mem_addr  <= lsu_addr;
              mem_wen   <= lsu_wen;
              mem_wdata <= lsu_wdata;
              mem_wmask <= lsu_wmask;
            end else begin
              mem_addr  <= ifu_addr;
              mem_wen   <= 1'b0;
              mem_wdata <= '0;
              mem_wmask <= '0;
            end
          end
        end
        REQ: begin
          if (timeout) begin
            state <= IDLE;
          end else begin
            if (mem_req_ready) state <= WAIT;
            if (cnt != '1) cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (fire) begin
            state <= IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [AW-1:0]   ifu_addr;
  logic [DW-1:0]   ifu_rdata;
  logic            lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [AW-1:0]   lsu_addr;
  logic [DW-1:0]   lsu_wdata, lsu_rdata;
  logic [DW/8-1:0] lsu_wmask;
  logic            mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, bus_err;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic [DW/8-1:0] mem_wmask;

  typedef struct packed {
    logic          owner;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Response monitor: every resp strobe must match the oldest outstanding expectation
  always @(negedge clk) begin : monitor
    exp_t          e;
    logic          got_owner;
    logic [DW-1:0] got_data;
    if (!rst && (ifu_resp_valid || lsu_resp_valid)) begin
      vectors++;
      got_owner = lsu_resp_valid ? OWN_LSU : OWN_IFU;
      got_data  = lsu_resp_valid ? lsu_rdata : ifu_rdata;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL stray_resp: ifu_resp=%b lsu_resp=%b with nothing outstanding", ifu_resp_valid, lsu_resp_valid);
      end else begin
        e = sb.pop_front();
        if ((ifu_resp_valid && lsu_resp_valid) || got_owner !== e.owner || got_data !== e.data || bus_err !== e.err) begin
          miscompares++;
          $display("FAIL resp: got ifu=%b lsu=%b data=%h err=%b, want owner=%b data=%h err=%b",
                   ifu_resp_valid, lsu_resp_valid, got_data, bus_err, e.owner, e.data, e.err);
        end
      end
    end else if (!rst && bus_err) begin
      vectors++;
      miscompares++;
      $display("FAIL bus_err_alone: bus_err=1 without resp_valid");
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1;
    ifu_req_valid = 1; lsu_req_valid = 1;
    #2;
    vectors++; if ({ifu_req_ready, lsu_req_ready, mem_req_valid} !== 3'b000) begin miscompares++; $display("FAIL reset_ready_valid: got %b want 000", {ifu_req_ready, lsu_req_ready, mem_req_valid}); end
    vectors++; if ({ifu_resp_valid, lsu_resp_valid, bus_err} !== 3'b000) begin miscompares++; $display("FAIL reset_resp: got %b want 000", {ifu_resp_valid, lsu_resp_valid, bus_err}); end
    vectors++; if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== '0) begin miscompares++; $display("FAIL reset_mem_fields: addr=%h wen=%b wdata=%h wmask=%h want all 0", mem_addr, mem_wen, mem_wdata, mem_wmask); end
    ifu_req_valid = 0; lsu_req_valid = 0;
    step(); step();
    rst = 0;
  endtask

  task automatic test_ifu_read;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000; lsu_wdata = 32'hFFFF_FFFF;
    #1;
    vectors++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin miscompares++; $display("FAIL ifu_read_ready: got %b want 10", {ifu_req_ready, lsu_req_ready}); end
    sb.push_back('{owner: OWN_IFU, data: 32'h0010_0073, err: 1'b0});
    step();
    ifu_req_valid = 0; mem_req_ready = 1;
    #1;
    vectors++; if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !== {1'b1, 32'h8000_0000, 1'b0, 32'h0, 4'h0}) begin miscompares++; $display("FAIL ifu_read_req: valid=%b addr=%h wen=%b wdata=%h wmask=%h", mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask); end
    step();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0010_0073;
    #1;
    vectors++; if ({ifu_resp_valid, lsu_resp_valid, ifu_rdata} !== {2'b10, 32'h0010_0073}) begin miscompares++; $display("FAIL ifu_read_resp: ifu=%b lsu=%b rdata=%h want 1 0 00100073", ifu_resp_valid, lsu_resp_valid, ifu_rdata); end
    step();
    mem_resp_valid = 0; lsu_wdata = '0;
  endtask

  task automatic test_round_robin;
    logic want_lsu;
    rst = 1; step(); rst = 0;
    ifu_req_valid = 1; ifu_addr = 32'h0000_A000;
    lsu_req_valid = 1; lsu_addr = 32'h0000_B000; lsu_wen = 0;
    for (int i = 0; i < 3; i++) begin
      want_lsu = (i == 1);
      #1;
      vectors++; if ({lsu_req_ready, ifu_req_ready} !== (want_lsu ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL rr_grant_%0d: lsu_ready=%b ifu_ready=%b want_lsu=%b", i, lsu_req_ready, ifu_req_ready, want_lsu); end
      sb.push_back('{owner: want_lsu, data: DW'(32'h1000 + i), err: 1'b0});
      step();
      if (i == 2) begin ifu_req_valid = 0; lsu_req_valid = 0; end
      mem_req_ready = 1;
      #1;
      vectors++; if ({lsu_req_ready, ifu_req_ready, mem_addr} !== {2'b00, (want_lsu ? 32'h0000_B000 : 32'h0000_A000)}) begin miscompares++; $display("FAIL rr_busy_%0d: readies=%b%b addr=%h", i, lsu_req_ready, ifu_req_ready, mem_addr); end
      step();
      mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = DW'(32'h1000 + i);
      step();
      mem_resp_valid = 0;
    end
  endtask

  task automatic test_lsu_write;
    lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    #1;
    vectors++; if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin miscompares++; $display("FAIL wr_ready: got %b want 10", {lsu_req_ready, ifu_req_ready}); end
    sb.push_back('{owner: OWN_LSU, data: 32'h5A5A_5A5A, err: 1'b0});
    step();
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0; mem_req_ready = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++; if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !== {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF}) begin miscompares++; $display("FAIL wr_stable_%0d: valid=%b addr=%h wen=%b wdata=%h wmask=%h", k, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask); end
      step();
    end
    mem_req_ready = 1;
    step();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h5A5A_5A5A;
    #1;
    vectors++; if ({lsu_resp_valid, ifu_resp_valid} !== 2'b10) begin miscompares++; $display("FAIL wr_ack: lsu=%b ifu=%b want 1 0", lsu_resp_valid, ifu_resp_valid); end
    step();
    mem_resp_valid = 0;
    #1;
    vectors++; if (lsu_resp_valid !== 1'b0) begin miscompares++; $display("FAIL wr_ack_one_cycle: lsu_resp_valid=%b want 0", lsu_resp_valid); end
  endtask

  task automatic test_timeout(input bit race);
    ifu_req_valid = 1; ifu_addr = 32'h8000_0100; mem_rdata = 32'h1234_5678;
    #1;
    vectors++; if (ifu_req_ready !== 1'b1) begin miscompares++; $display("FAIL to_ready: got %b want 1", ifu_req_ready); end
    sb.push_back(race ? '{owner: OWN_IFU, data: 32'hCAFE_F00D, err: 1'b0} : '{owner: OWN_IFU, data: '0, err: 1'b1});
    step();
    ifu_req_valid = 0; mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    for (int k = 2; k < TO; k++) begin
      #1;
      vectors++; if ({ifu_resp_valid, bus_err} !== 2'b00) begin miscompares++; $display("FAIL to_early_%0d: resp=%b err=%b want 0 0", k, ifu_resp_valid, bus_err); end
      step();
    end
    if (race) begin mem_resp_valid = 1; mem_rdata = 32'hCAFE_F00D; end
    #1;
    vectors++; if ({ifu_resp_valid, bus_err, ifu_rdata} !== (race ? {2'b10, 32'hCAFE_F00D} : {2'b11, 32'h0})) begin miscompares++; $display("FAIL to_fire_race%0d: resp=%b err=%b rdata=%h", race, ifu_resp_valid, bus_err, ifu_rdata); end
    step();
    mem_resp_valid = !race; mem_rdata = 32'h0BAD_0BAD;
    #1;
    vectors++; if ({ifu_resp_valid, lsu_resp_valid, bus_err, mem_req_valid} !== 4'b0000) begin miscompares++; $display("FAIL to_after_race%0d: ifu=%b lsu=%b err=%b mreq=%b want 0000", race, ifu_resp_valid, lsu_resp_valid, bus_err, mem_req_valid); end
    step();
    mem_resp_valid = 0;
  endtask

  task automatic test_reset_in_wait;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0200;
    #1;
    vectors++; if (ifu_req_ready !== 1'b1) begin miscompares++; $display("FAIL rw_ready: got %b want 1", ifu_req_ready); end
    step();
    ifu_req_valid = 0; mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    #2;
    rst = 1; mem_resp_valid = 1; mem_rdata = 32'h7777_7777; ifu_req_valid = 1; lsu_req_valid = 1;
    #1;
    vectors++; if ({ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid, bus_err} !== 6'b0) begin miscompares++; $display("FAIL rw_outputs: got %b want 000000", {ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid, bus_err}); end
    vectors++; if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== '0) begin miscompares++; $display("FAIL rw_mem_fields: addr=%h wen=%b want 0", mem_addr, mem_wen); end
    step();
    mem_resp_valid = 0; rst = 0;
    #1;
    vectors++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin miscompares++; $display("FAIL rw_regrant: ifu=%b lsu=%b want 1 0", ifu_req_ready, lsu_req_ready); end
    ifu_req_valid = 0; lsu_req_valid = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_round_robin();
    test_lsu_write();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_in_wait();
    step(); step();
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL sb_drain: %0d responses outstanding, want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
